// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg
// Shared AXI4-Lite definitions: response codes and the register-window
// range check. The core's AXI bridge reuses the response constants.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // True when a byte address falls inside a window of nregs 32-bit registers.
    // The address is widened to 64 bits so any bus address width up to 64 fits.
    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned nregs);
        logic [63:0] limit_s;
        limit_s = 64'(nregs) << 2;
        return (addr < limit_s);
    endfunction

endpackage

// File: rtl/axi4lite_slave_regfile_if.sv
// axi4lite_slave_regfile_if
// AXI4-Lite bus bundle between the core's AXI bridge (master) and the
// register file (slave).
//   AW: s_awaddr, s_awprot, s_awvalid -> / <- s_awready
//   W : s_wdata, s_wstrb, s_wvalid    -> / <- s_wready
//   B : <- s_bresp, s_bvalid          /  s_bready ->
//   AR: s_araddr, s_arprot, s_arvalid -> / <- s_arready
//   R : <- s_rdata, s_rresp, s_rvalid /  s_rready ->
interface axi4lite_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic [2:0]            s_awprot;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [STRB_WIDTH-1:0] s_wstrb;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic [2:0]            s_arprot;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;

    modport master (
        output s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arprot, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arprot, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/axi4lite_regfile_core.sv
// axi4lite_regfile_core
// Register array with one byte-strobed write port, one combinational read
// port and the whole array flattened onto regs_q.
//   axi_clk, axi_arstn : clock, async active-low reset (clears all registers)
//   wr_en/wr_idx/wr_data/wr_strb : write port, applied on the rising edge
//   rd_idx/rd_data     : combinational read port
//   regs_q             : register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
module axi4lite_regfile_core #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           axi_clk,
    input  logic                           axi_arstn,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]    wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic [$clog2(NUM_REGS)-1:0]    rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];

    // Register storage: cleared by reset, bytes replaced only where strobed
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (wr_strb[k]) begin
                    mem_r[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    // NUM_REGS is a power of two, so every index value names a real register
    assign rd_data = mem_r[rd_idx];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = mem_r[g];
    end

endmodule

// File: rtl/axi4lite_slave_regfile.sv
// axi4lite_slave_regfile
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
//   axi_clk, axi_arstn : clock, async active-low reset
//   s_axi              : AXI4-Lite slave bus (AW/W/B/AR/R)
//   regs_q             : live register contents, register i at [i*32 +: 32]
// AW and W each have a one-entry holding buffer; a write commits on the edge
// after both are full. Reads are captured into rdata on the AR handshake.
module axi4lite_slave_regfile
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                           axi_clk,
    input  logic                           axi_arstn,
    axi4lite_slave_regfile_if.slave        s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                  rst_done_r;
    logic                  aw_full_r;
    logic                  w_full_r;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic [STRB_WIDTH-1:0] w_strb_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  rvalid_r;
    logic [1:0]            rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic                  awready_s;
    logic                  wready_s;
    logic                  arready_s;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  ar_hs_s;
    logic                  commit_s;
    logic                  aw_in_range_s;
    logic                  ar_in_range_s;
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] core_rdata_s;
    logic                  unused_prot_s;

    // Readies come only from state flops, never from the valids
    assign awready_s     = rst_done_r & ~aw_full_r & ~bvalid_r;
    assign wready_s      = rst_done_r & ~w_full_r & ~bvalid_r;
    assign arready_s     = rst_done_r & ~rvalid_r;
    assign aw_hs_s       = s_axi.s_awvalid & awready_s;
    assign w_hs_s        = s_axi.s_wvalid & wready_s;
    assign ar_hs_s       = s_axi.s_arvalid & arready_s;
    assign commit_s      = aw_full_r & w_full_r;
    assign aw_in_range_s = addr_in_range(64'(aw_addr_r), NUM_REGS);
    assign ar_in_range_s = addr_in_range(64'(s_axi.s_araddr), NUM_REGS);
    assign wr_en_s       = commit_s & aw_in_range_s;
    assign unused_prot_s = ^{s_axi.s_awprot, s_axi.s_arprot};

    // Readies stay low for the first edge after reset release
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    // Write-address holding buffer; handshake and commit are mutually exclusive
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            aw_full_r <= 1'b0;
            aw_addr_r <= '0;
        end else if (aw_hs_s) begin
            aw_full_r <= 1'b1;
            aw_addr_r <= s_axi.s_awaddr;
        end else if (commit_s) begin
            aw_full_r <= 1'b0;
        end
    end

    // Write-data holding buffer
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            w_full_r <= 1'b0;
            w_data_r <= '0;
            w_strb_r <= '0;
        end else if (w_hs_s) begin
            w_full_r <= 1'b1;
            w_data_r <= s_axi.s_wdata;
            w_strb_r <= s_axi.s_wstrb;
        end else if (commit_s) begin
            w_full_r <= 1'b0;
        end
    end

    // Write response: raised on commit, held until the master takes it
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
        end else if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= aw_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_r & s_axi.s_bready) begin
            bvalid_r <= 1'b0;
        end
    end

    // Read response: data sampled on the AR handshake (pre-write on collision)
    always_ff @(posedge axi_clk or negedge axi_arstn) begin
        if (!axi_arstn) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= '0;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= ar_in_range_s ? RESP_OKAY : RESP_SLVERR;
            rdata_r  <= ar_in_range_s ? core_rdata_s : '0;
        end else if (rvalid_r & s_axi.s_rready) begin
            rvalid_r <= 1'b0;
        end
    end

    axi4lite_regfile_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_core (
        .axi_clk   (axi_clk),
        .axi_arstn (axi_arstn),
        .wr_en     (wr_en_s),
        .wr_idx    (aw_addr_r[IDX_W+1:2]),
        .wr_data   (w_data_r),
        .wr_strb   (w_strb_r),
        .rd_idx    (s_axi.s_araddr[IDX_W+1:2]),
        .rd_data   (core_rdata_s),
        .regs_q    (regs_q)
    );

    assign s_axi.s_awready = awready_s;
    assign s_axi.s_wready  = wready_s;
    assign s_axi.s_bvalid  = bvalid_r;
    assign s_axi.s_bresp   = bresp_r;
    assign s_axi.s_arready = arready_s;
    assign s_axi.s_rvalid  = rvalid_r;
    assign s_axi.s_rresp   = rresp_r;
    assign s_axi.s_rdata   = rdata_r;

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// tb_axi4lite_slave_regfile
// Self-checking bench: directed scenarios plus a randomized mix of reads and
// writes, checked against a plain array model of the register bank.
module tb_axi4lite_slave_regfile;
    localparam int NREGS = 16;

    logic                  axi_clk = 1'b0;
    logic                  axi_arstn;
    logic [NREGS*32-1:0]   regs_q;
    logic [31:0]           model_regs [NREGS];
    int                    tests_run = 0;
    int                    tests_failed = 0;

    axi4lite_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4lite_slave_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .STRB_WIDTH (4),
        .NUM_REGS   (NREGS)
    ) dut (
        .axi_clk   (axi_clk),
        .axi_arstn (axi_arstn),
        .s_axi     (bus.slave),
        .regs_q    (regs_q)
    );

    always #5 axi_clk = ~axi_clk;

    // ---------------- reference model ----------------
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        if (addr >= 32'(NREGS * 4)) return 2'b10;
        idx = int'(addr / 32'd4);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] addr);
        if (addr >= 32'(NREGS * 4)) return {2'b10, 32'h0};
        return {2'b00, model_regs[int'(addr / 32'd4)]};
    endfunction

    function automatic logic [NREGS*32-1:0] model_flat();
        logic [NREGS*32-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i*32 +: 32] = model_regs[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
    endtask

    // ---------------- bus drivers (no checking) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int lat, output bit timeout, output bit perr);
        int cyc, hs_cyc, b_cyc;
        bit aw_done, w_done, got_b, hs_aw, hs_w, hs_b;
        aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0; perr = 1'b0;
        lat = -1; resp = 2'b11; cyc = 0; hs_cyc = 0; b_cyc = 0;
        bus.s_awaddr = addr; bus.s_awprot = 3'($urandom);
        bus.s_wdata = data; bus.s_wstrb = strb; bus.s_bready = 1'b0;
        while (!got_b && cyc < 100) begin
            bus.s_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s_wvalid  = !w_done && (cyc >= w_dly);
            hs_aw = bus.s_awvalid && bus.s_awready;
            hs_w  = bus.s_wvalid && bus.s_wready;
            hs_b  = bus.s_bvalid && bus.s_bready;
            @(posedge axi_clk); #1; cyc++;
            if (hs_aw) begin aw_done = 1'b1; hs_cyc = cyc; end
            if (hs_w)  begin w_done = 1'b1;  hs_cyc = cyc; end
            if (hs_b) begin
                got_b = 1'b1;
            end else if (bus.s_bvalid) begin
                if (!(aw_done && w_done)) perr = 1'b1;
                if (lat < 0) begin
                    lat = cyc - hs_cyc + 1; resp = bus.s_bresp; b_cyc = cyc;
                end else if (bus.s_bresp !== resp) begin
                    perr = 1'b1;
                end
                if (bus.s_awready || bus.s_wready) perr = 1'b1;
                bus.s_bready = (cyc - b_cyc >= b_dly);
            end
        end
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
        timeout = !got_b;
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp, output int lat,
                           output bit timeout, output bit perr);
        int cyc, hs_cyc, r_cyc;
        bit ar_done, got_r, hs_ar, hs_r;
        ar_done = 1'b0; got_r = 1'b0; perr = 1'b0;
        lat = -1; resp = 2'b11; data = 32'hx; cyc = 0; hs_cyc = 0; r_cyc = 0;
        bus.s_araddr = addr; bus.s_arprot = 3'($urandom); bus.s_rready = 1'b0;
        while (!got_r && cyc < 100) begin
            bus.s_arvalid = !ar_done && (cyc >= ar_dly);
            hs_ar = bus.s_arvalid && bus.s_arready;
            hs_r  = bus.s_rvalid && bus.s_rready;
            @(posedge axi_clk); #1; cyc++;
            if (hs_ar) begin ar_done = 1'b1; hs_cyc = cyc; end
            if (hs_r) begin
                got_r = 1'b1;
            end else if (bus.s_rvalid) begin
                if (!ar_done) perr = 1'b1;
                if (lat < 0) begin
                    lat = cyc - hs_cyc + 1; resp = bus.s_rresp; data = bus.s_rdata; r_cyc = cyc;
                end else if (bus.s_rresp !== resp || bus.s_rdata !== data) begin
                    perr = 1'b1;
                end
                if (bus.s_arready) perr = 1'b1;
                bus.s_rready = (cyc - r_cyc >= r_dly);
            end
        end
        bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        timeout = !got_r;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
        bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        bus.s_awaddr = 32'h0; bus.s_wdata = 32'h0; bus.s_wstrb = 4'h0; bus.s_araddr = 32'h0;
        bus.s_awprot = 3'b000; bus.s_arprot = 3'b000;
        axi_arstn = 1'b0;
        model_clear();
        repeat (3) @(posedge axi_clk);
        #1;
        tests_run++;
        if ({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid});
        end
        tests_run++;
        if ({bus.s_bresp, bus.s_rresp, bus.s_rdata} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_resp_data: got %h expected 0", {bus.s_bresp, bus.s_rresp, bus.s_rdata});
        end
        tests_run++;
        if (regs_q !== '0) begin tests_failed++; $display("FAIL reset_regs: got %h expected 0", regs_q); end
        axi_arstn = 1'b1;
        #1;
        tests_run++;
        if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b000) begin
            tests_failed++; $display("FAIL ready_after_release: got %b expected 000", {bus.s_awready, bus.s_wready, bus.s_arready});
        end
        @(posedge axi_clk); #1;
        tests_run++;
        if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b111) begin
            tests_failed++; $display("FAIL ready_one_cycle: got %b expected 111", {bus.s_awready, bus.s_wready, bus.s_arready});
        end
    endtask

    task automatic test_same_cycle_write();
        logic [1:0] resp, exp_resp; logic [31:0] data; int lat; bit to, perr;
        exp_resp = model_write(32'h04, 32'hDEADBEEF, 4'hF);
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 2, resp, lat, to, perr);
        tests_run++;
        if (to || perr || lat != 2 || resp !== exp_resp) begin
            tests_failed++; $display("FAIL same_cycle_write: to=%0d perr=%0d lat=%0d resp=%b, expected lat 2 resp %b", to, perr, lat, resp, exp_resp);
        end
        tests_run++;
        if (regs_q[63:32] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL reg1_value: got %h expected deadbeef", regs_q[63:32]); end
        do_read(32'h04, 0, 1, data, resp, lat, to, perr);
        tests_run++;
        if (to || perr || lat != 1 || data !== 32'hDEADBEEF || resp !== 2'b00) begin
            tests_failed++; $display("FAIL read_back: to=%0d perr=%0d lat=%0d data=%h resp=%b, expected lat 1 deadbeef 00", to, perr, lat, data, resp);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; int lat; bit to, perr;
        void'(model_write(32'h08, 32'hAABBCCDD, 4'hF));
        do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0, resp, lat, to, perr);
        tests_run++;
        if (to || perr || resp !== 2'b00) begin tests_failed++; $display("FAIL preload: to=%0d perr=%0d resp=%b expected 00", to, perr, resp); end
        void'(model_write(32'h08, 32'h11223344, 4'b0101));
        do_write(32'h08, 32'h11223344, 4'b0101, 5, 0, 0, resp, lat, to, perr);
        tests_run++;
        if (to || perr || lat != 2 || resp !== 2'b00) begin
            tests_failed++; $display("FAIL w_first_handshake: to=%0d early_or_unstable=%0d lat=%0d resp=%b, expected 0 0 2 00", to, perr, lat, resp);
        end
        tests_run++;
        if (regs_q[95:64] !== 32'hAA22CC44 || regs_q !== model_flat()) begin
            tests_failed++; $display("FAIL strobe_merge: got %h expected aa22cc44", regs_q[95:64]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] data; int lat; bit to, perr;
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0, resp, lat, to, perr);
        tests_run++;
        if (to || perr || resp !== 2'b10) begin tests_failed++; $display("FAIL oor_write_resp: to=%0d perr=%0d resp=%b expected 10", to, perr, resp); end
        tests_run++;
        if (regs_q !== model_flat()) begin tests_failed++; $display("FAIL oor_no_write: got %h expected %h", regs_q, model_flat()); end
        do_read(32'h40, 0, 0, data, resp, lat, to, perr);
        tests_run++;
        if (to || perr || data !== 32'h0 || resp !== 2'b10) begin
            tests_failed++; $display("FAIL oor_read: to=%0d perr=%0d data=%h resp=%b expected 0 10", to, perr, data, resp);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] wdata; logic [33:0] exp_r; logic [1:0] exp_b;
        logic [41:0] snap, exp_snap;
        wdata = $urandom;
        exp_r = model_read(32'h0C);
        exp_b = model_write(32'h14, wdata, 4'hF);
        bus.s_awaddr = 32'h14; bus.s_wdata = wdata; bus.s_wstrb = 4'hF; bus.s_araddr = 32'h0C;
        bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        @(posedge axi_clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        @(posedge axi_clk); #1;
        exp_snap = {1'b1, exp_b, 1'b1, exp_r[33:32], exp_r[31:0], 3'b000};
        for (int c = 0; c < 10; c++) begin
            snap = {bus.s_bvalid, bus.s_bresp, bus.s_rvalid, bus.s_rresp, bus.s_rdata,
                    bus.s_awready, bus.s_wready, bus.s_arready};
            tests_run++;
            if (snap !== exp_snap) begin tests_failed++; $display("FAIL backpressure_hold c%0d: got %h expected %h", c, snap, exp_snap); end
            @(posedge axi_clk); #1;
        end
        tests_run++;
        if (regs_q !== model_flat()) begin tests_failed++; $display("FAIL backpressure_regs: got %h expected %h", regs_q, model_flat()); end
        bus.s_bready = 1'b1; bus.s_rready = 1'b1;
        @(posedge axi_clk); #1;
        bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        tests_run++;
        if ({bus.s_bvalid, bus.s_rvalid} !== 2'b00) begin tests_failed++; $display("FAIL resp_release: got %b expected 00", {bus.s_bvalid, bus.s_rvalid}); end
    endtask

    task automatic test_collision();
        logic [1:0] resp; logic [31:0] data, old_v; int lat; bit to, perr;
        void'(model_write(32'h0C, 32'h0, 4'hF));
        do_write(32'h0C, 32'h0, 4'hF, 0, 0, 0, resp, lat, to, perr);
        old_v = model_regs[3];
        void'(model_write(32'h0C, 32'h5, 4'hF));
        bus.s_awaddr = 32'h0C; bus.s_wdata = 32'h5; bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        @(posedge axi_clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        bus.s_araddr = 32'h0C; bus.s_arvalid = 1'b1;
        @(posedge axi_clk); #1;
        bus.s_arvalid = 1'b0;
        tests_run++;
        if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== old_v || bus.s_bvalid !== 1'b1) begin
            tests_failed++; $display("FAIL collision_old: rvalid=%b bvalid=%b rdata=%h expected 1 1 %h", bus.s_rvalid, bus.s_bvalid, bus.s_rdata, old_v);
        end
        tests_run++;
        if (regs_q !== model_flat()) begin tests_failed++; $display("FAIL collision_regs: got %h expected %h", regs_q[127:96], model_regs[3]); end
        bus.s_bready = 1'b1; bus.s_rready = 1'b1;
        @(posedge axi_clk); #1;
        bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        do_read(32'h0C, 0, 0, data, resp, lat, to, perr);
        tests_run++;
        if (to || perr || data !== 32'h5 || resp !== 2'b00) begin
            tests_failed++; $display("FAIL collision_new: to=%0d data=%h resp=%b expected 00000005 00", to, data, resp);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, data, rdata; logic [3:0] strb; logic [1:0] resp, exp_resp;
        logic [33:0] exp_r; int lat; bit to, perr;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = 32'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom; strb = 4'($urandom);
                exp_resp = model_write(addr, data, strb);
                do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         resp, lat, to, perr);
                tests_run++;
                if (to || perr || lat != 2 || resp !== exp_resp || regs_q !== model_flat()) begin
                    tests_failed++;
                    $display("FAIL rand_write n%0d addr %h: to=%0d perr=%0d lat=%0d resp=%b expected lat 2 resp %b", n, addr, to, perr, lat, resp, exp_resp);
                end
            end else begin
                exp_r = model_read(addr);
                do_read(addr, $urandom_range(0, 3), $urandom_range(0, 3), rdata, resp, lat, to, perr);
                tests_run++;
                if (to || perr || lat != 1 || {resp, rdata} !== exp_r) begin
                    tests_failed++;
                    $display("FAIL rand_read n%0d addr %h: to=%0d perr=%0d lat=%0d got %h expected %h", n, addr, to, perr, lat, {resp, rdata}, exp_r);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [1:0] resp; int lat; bit to, perr;
        bus.s_awaddr = 32'h10; bus.s_awvalid = 1'b1;
        bus.s_araddr = 32'h04; bus.s_arvalid = 1'b1; bus.s_rready = 1'b0;
        @(posedge axi_clk); #1;
        bus.s_awvalid = 1'b0; bus.s_arvalid = 1'b0;
        tests_run++;
        if (bus.s_rvalid !== 1'b1) begin tests_failed++; $display("FAIL midflight_setup: rvalid=%b expected 1", bus.s_rvalid); end
        #2 axi_arstn = 1'b0;
        #1;
        model_clear();
        tests_run++;
        if ({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid, bus.s_bresp, bus.s_rresp, bus.s_rdata} !== 41'h0) begin
            tests_failed++; $display("FAIL midflight_reset_outputs: got %h expected 0", {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid, bus.s_bresp, bus.s_rresp, bus.s_rdata});
        end
        tests_run++;
        if (regs_q !== '0) begin tests_failed++; $display("FAIL midflight_regs: got %h expected 0", regs_q); end
        @(posedge axi_clk); #1;
        axi_arstn = 1'b1;
        void'(model_write(32'h08, 32'h600DCAFE, 4'hF));
        do_write(32'h08, 32'h600DCAFE, 4'hF, 4, 0, 0, resp, lat, to, perr);
        tests_run++;
        if (to || perr || lat != 2 || resp !== 2'b00 || regs_q !== model_flat()) begin
            tests_failed++; $display("FAIL post_reset_write: to=%0d stale_or_unstable=%0d lat=%0d resp=%b reg2=%h expected 600dcafe", to, perr, lat, resp, regs_q[95:64]);
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
